// File: rtl/sgdmac_rd_sched.sv
// sgdmac_rd_sched: round-robin AR scheduler for the SG-DMA read path with
// per-master outstanding-burst accounting driven by the R channel.
module sgdmac_rd_sched #(
  parameter int unsigned N_MASTER   = 2,
  parameter int unsigned DATA_SIZE  = 41,
  parameter int unsigned MAX_OUTSTD = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTER-1:0]             req_valid_i,
  input  logic [N_MASTER*DATA_SIZE-1:0]   req_data_i,
  output logic [N_MASTER-1:0]             req_ready_o,
  output logic                            arvalid_o,
  input  logic                            arready_i,
  output logic [3:0]                      arid_o,
  output logic [DATA_SIZE-1:0]            ar_data_o,
  input  logic                            rvalid_i,
  input  logic                            rlast_i,
  input  logic [3:0]                      rid_i,
  input  logic [N_MASTER-1:0]             rready_i,
  output logic                            rready_o,
  output logic [N_MASTER*4-1:0]           outstd_o,
  output logic                            bad_rid_o
);

  localparam int unsigned CW = 4;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]                   state_q;
  logic [0:0]                   state_d;
  logic [CW-1:0]                last_grant_q;
  logic [N_MASTER-1:0][CW-1:0]  outstd_q;

  logic [N_MASTER-1:0]          elig;
  logic                         win_found;
  logic [CW-1:0]                win_idx;
  logic [DATA_SIZE-1:0]         win_data;
  logic                         rid_known;
  logic                         grant;
  logic                         ar_hs;
  logic                         r_done;
  logic [N_MASTER-1:0]          inc_vec;
  logic [N_MASTER-1:0]          dec_vec;

  // Eligibility: requesting and below the outstanding-burst ceiling
  always_comb begin
    elig = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      elig[m] = req_valid_i[m] && (outstd_q[m] < CW'(MAX_OUTSTD));
    end
  end

  // Round-robin pick: first eligible above last_grant, else first eligible from 0
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      if (!win_found && elig[m] && (CW'(m) > last_grant_q)) begin
        win_found = 1'b1;
        win_idx   = CW'(m);
      end
    end
    for (int m = 0; m < N_MASTER; m++) begin
      if (!win_found && elig[m]) begin
        win_found = 1'b1;
        win_idx   = CW'(m);
      end
    end
  end

  // Payload mux for the winner
  always_comb begin
    win_data = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      if (win_idx == CW'(m)) begin
        win_data = req_data_i[m*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Accept strobe toward the winner, only while idle and out of reset
  always_comb begin
    req_ready_o = '0;
    if (rst_n && (state_q == S_IDLE) && win_found) begin
      for (int m = 0; m < N_MASTER; m++) begin
        req_ready_o[m] = (win_idx == CW'(m));
      end
    end
  end

  // R-ready routing; beats with unknown IDs are drained
  always_comb begin
    rid_known = (rid_i < CW'(N_MASTER));
    rready_o  = 1'b1;
    for (int m = 0; m < N_MASTER; m++) begin
      if (rid_i == CW'(m)) begin
        rready_o = rready_i[m];
      end
    end
  end

  // Next-state logic and per-master counter update strobes
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    ar_hs   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (arready_i) begin
          ar_hs   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    r_done  = rvalid_i && rready_o && rlast_i && rid_known;
    inc_vec = '0;
    dec_vec = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      inc_vec[m] = ar_hs && (arid_o == CW'(m));
      dec_vec[m] = r_done && (rid_i == CW'(m));
    end
  end

  // State, AR payload, grant pointer, counters and bad-ID flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      arid_o       <= '0;
      ar_data_o    <= '0;
      last_grant_q <= CW'(N_MASTER - 1);
      outstd_q     <= '0;
      bad_rid_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bad_rid_o <= rvalid_i && !rid_known;
      if (grant) begin
        arid_o       <= win_idx;
        ar_data_o    <= win_data;
        last_grant_q <= win_idx;
      end
      for (int m = 0; m < N_MASTER; m++) begin
        if (inc_vec[m] && !dec_vec[m]) begin
          outstd_q[m] <= outstd_q[m] + CW'(1);
        end else if (dec_vec[m] && !inc_vec[m] && (outstd_q[m] != '0)) begin
          outstd_q[m] <= outstd_q[m] - CW'(1);
        end
      end
    end
  end

  assign arvalid_o = (state_q == S_ISSUE);
  assign outstd_o  = outstd_q;

endmodule

// File: tb/tb_sgdmac_rd_sched.sv
// Testbench for sgdmac_rd_sched: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_sgdmac_rd_sched;

  localparam int N  = 2;
  localparam int DS = 41;
  localparam int MO = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid_i;
  logic [N*DS-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic            arvalid_o;
  logic            arready_i;
  logic [3:0]      arid_o;
  logic [DS-1:0]   ar_data_o;
  logic            rvalid_i;
  logic            rlast_i;
  logic [3:0]      rid_i;
  logic [N-1:0]    rready_i;
  logic            rready_o;
  logic [N*4-1:0]  outstd_o;
  logic            bad_rid_o;

  sgdmac_rd_sched #(.N_MASTER(N), .DATA_SIZE(DS), .MAX_OUTSTD(MO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .arid_o      (arid_o),
    .ar_data_o   (ar_data_o),
    .rvalid_i    (rvalid_i),
    .rlast_i     (rlast_i),
    .rid_i       (rid_i),
    .rready_i    (rready_i),
    .rready_o    (rready_o),
    .outstd_o    (outstd_o),
    .bad_rid_o   (bad_rid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one pending AR (if any), RR pointer, per-master burst counts
  bit            m_busy;
  int            m_id;
  logic [DS-1:0] m_data;
  int            m_last;
  int            m_cnt [N];
  bit            m_bad;

  int got [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_data = '0;
    m_last = N - 1;
    for (int m = 0; m < N; m++) m_cnt[m] = 0;
    m_bad  = 1'b0;
  endtask

  task automatic idle_inputs();
    rst_n       = 1'b1;
    req_valid_i = '0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rlast_i     = 1'b0;
    rid_i       = '0;
    rready_i    = '0;
  endtask

  task automatic new_data();
    req_data_i = (N*DS)'({$urandom(), $urandom(), $urandom()});
  endtask

  // Compare all outputs with the model for the current cycle, then advance one clock
  task automatic step();
    int           win;
    int           c;
    logic [N-1:0] exp_ready;
    logic         exp_rr;
    #1;
    win = -1;
    if (rst_n && !m_busy) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (win < 0 && req_valid_i[c] && m_cnt[c] < MO) win = c;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    exp_rr = (int'(rid_i) < N) ? rready_i[rid_i] : 1'b1;

    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    chk("rready",    64'(rready_o),    64'(exp_rr));
    chk("arvalid",   64'(arvalid_o),   64'(m_busy));
    chk("arid",      64'(arid_o),      64'(m_id));
    chk("ar_data",   64'(ar_data_o),   64'(m_data));
    chk("bad_rid",   64'(bad_rid_o),   64'(m_bad));
    for (int m = 0; m < N; m++) chk("outstd", 64'(outstd_o[m*4 +: 4]), 64'(m_cnt[m]));

    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_busy && arready_i) begin
        m_cnt[m_id]++;
        m_busy = 1'b0;
      end
      if (rvalid_i && exp_rr && rlast_i && int'(rid_i) < N && m_cnt[rid_i] > 0)
        m_cnt[rid_i]--;
      m_bad = rvalid_i && (int'(rid_i) >= N);
      if (win >= 0) begin
        m_busy = 1'b1;
        m_id   = win;
        m_data = req_data_i[win*DS +: DS];
        m_last = win;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    new_data();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step();
    step();

    // Both masters requesting, AR always ready: alternating grants
    idle_inputs();
    req_valid_i = 2'b11;
    arready_i   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      new_data();
      step();
      if (arvalid_o === 1'b1) got.push_back(int'(arid_o));
    end
    chk("rr_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("rr_seq", 64'(got[i]), 64'(i % 2));
    end

    // Master 1 alone with AR stalled; request withdrawn after the grant
    do_reset();
    req_valid_i = 2'b10;
    new_data();
    for (int i = 0; i < 6; i++) step();
    req_valid_i = 2'b00;
    new_data();
    arready_i   = 1'b1;
    step();
    arready_i   = 1'b0;
    #1;
    chk("stall_cnt1", 64'(outstd_o[7:4]), 64'(1));
    step();

    // Master 0 hits the outstanding ceiling, then one completing beat frees it
    do_reset();
    req_valid_i = 2'b01;
    arready_i   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      new_data();
      step();
    end
    req_valid_i = 2'b11;
    #1;
    chk("full_ready", 64'(req_ready_o), 64'(2'b10));
    step();
    rvalid_i = 1'b1;
    rlast_i  = 1'b1;
    rid_i    = 4'd0;
    rready_i = 2'b01;
    step();
    rvalid_i = 1'b0;
    #1;
    chk("refill_ready", 64'(req_ready_o), 64'(2'b01));
    step();

    // Simultaneous AR handshake and last beat on master 1 at count 2
    do_reset();
    req_valid_i = 2'b10;
    arready_i   = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rvalid_i = 1'b1;
    rlast_i  = 1'b1;
    rid_i    = 4'd1;
    rready_i = 2'b10;
    step();
    rvalid_i    = 1'b0;
    req_valid_i = 2'b00;
    #1;
    chk("same_cyc_cnt1", 64'(outstd_o[7:4]), 64'(2));
    step();

    // Unknown ID beat is drained and flagged for exactly one cycle
    rvalid_i = 1'b1;
    rlast_i  = 1'b1;
    rid_i    = 4'd3;
    rready_i = 2'b00;
    #1;
    chk("bad_rready", 64'(rready_o), 64'(1));
    step();
    rvalid_i = 1'b0;
    #1;
    chk("bad_pulse", 64'(bad_rid_o), 64'(1));
    step();
    chk("bad_clear", 64'(bad_rid_o), 64'(0));
    chk("bad_cnt1", 64'(outstd_o[7:4]), 64'(2));

    // Reset while an AR is pending with arready high
    req_valid_i = 2'b11;
    arready_i   = 1'b0;
    new_data();
    step();
    rst_n     = 1'b0;
    arready_i = 1'b1;
    step();
    rst_n     = 1'b1;
    arready_i = 1'b0;
    #1;
    chk("rst_arvalid", 64'(arvalid_o), 64'(0));
    chk("rst_outstd", 64'(outstd_o), 64'(0));
    chk("rst_first", 64'(req_ready_o), 64'(2'b01));
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      req_valid_i = N'($urandom());
      new_data();
      arready_i   = ($urandom_range(0, 9) < 7);
      rvalid_i    = ($urandom_range(0, 9) < 4);
      rlast_i     = ($urandom_range(0, 9) < 6);
      rid_i       = 4'($urandom_range(0, 3));
      rready_i    = N'($urandom());
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sgdmac_rd_sched.md
SGDMAC_RD_SCHED -- requirements
Module: sgdmac_rd_sched

Interface
REQ-001 Parameter N_MASTER, default 2: number of AR requesters; index 0 is the descriptor fetcher, index 1 is the data reader.
REQ-002 Parameter DATA_SIZE, default 41: width of each request payload {araddr, arlen, arsize, arburst}.
REQ-003 Parameter MAX_OUTSTD, default 4: maximum outstanding read bursts per master, range 1..15.
REQ-004 Port clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port req_valid_i  input  N_MASTER  per-master request valid.
REQ-007 Port req_data_i  input  N_MASTER*DATA_SIZE  per-master payload; master m occupies slice [m*DATA_SIZE +: DATA_SIZE].
REQ-008 Port req_ready_o  output  N_MASTER  per-master accept; one-hot or zero.
REQ-009 Port arvalid_o  output  1  registered AR valid toward AXI.
REQ-010 Port arready_i  input  1  AXI AR ready.
REQ-011 Port arid_o  output  4  granted master index, zero-extended.
REQ-012 Port ar_data_o  output  DATA_SIZE  registered payload of the granted master.
REQ-013 Port rvalid_i, rlast_i  input  1 each  AXI R valid and last.
REQ-014 Port rid_i  input  4  AXI R ID.
REQ-015 Port rready_i  input  N_MASTER  per-master R ready.
REQ-016 Port rready_o  output  1  routed R ready toward AXI.
REQ-017 Port outstd_o  output  N_MASTER*4  per-master outstanding burst count.
REQ-018 Port bad_rid_o  output  1  single-cycle pulse on an R beat whose rid_i >= N_MASTER.

Function
REQ-019 The FSM SHALL have two states: IDLE and ISSUE.
REQ-020 Master m SHALL be eligible when req_valid_i[m]=1 and outstd[m] < MAX_OUTSTD, evaluated on registered counts.
REQ-021 In IDLE with at least one eligible master, the block SHALL pick the winner round-robin, starting from index (last_grant+1) mod N_MASTER.
REQ-022 In that same cycle, the block SHALL assert req_ready_o for the winner only, latch its payload into ar_data_o and its index into arid_o, update last_grant, and enter ISSUE.
REQ-023 req_ready_o SHALL be combinational, nonzero only in IDLE, and zero whenever no master is eligible.
REQ-024 arvalid_o SHALL be 1 exactly while in ISSUE; ar_data_o and arid_o SHALL stay stable while arvalid_o=1 and arready_i=0.
REQ-025 In ISSUE, arvalid_o=1 with arready_i=1 SHALL complete the handshake, increment outstd[arid_o], and return the FSM to IDLE.
REQ-026 Grant-to-grant spacing SHALL be at least 2 cycles (one IDLE bubble); AR latency from req_valid_i to arvalid_o SHALL be 1 cycle.
REQ-027 rready_o SHALL equal rready_i[rid_i] when rid_i < N_MASTER, and 1 otherwise (drain unknown IDs).
REQ-028 When rvalid_i, rready_o and rlast_i are all 1 and rid_i < N_MASTER, outstd[rid_i] SHALL decrement.
REQ-029 An increment and a decrement on the same master in the same cycle SHALL leave outstd unchanged.
REQ-030 A decrement when outstd[m]=0 SHALL saturate at 0; it SHALL NOT wrap.
REQ-031 bad_rid_o SHALL pulse for one cycle on each R handshake with rid_i >= N_MASTER, and no counter SHALL change.
REQ-032 A master that drops req_valid_i before being granted SHALL NOT affect the FSM; a grant already latched SHALL still be issued.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, arvalid_o=0, arid_o=0, ar_data_o=0, all outstd=0, last_grant=N_MASTER-1 (so master 0 wins first), and bad_rid_o=0.
REQ-034 A reset asserted during ISSUE SHALL drop arvalid_o on the next cycle with no counter update, even if arready_i=1 in that cycle.
REQ-035 req_ready_o SHALL be 0 while rst_n=0.

Verification
REQ-036 After reset, both masters requesting continuously with arready_i=1 -> arid_o sequence 0,1,0,1 and arvalid_o high every other cycle.
REQ-037 Master 1 only, arready_i held 0 for 5 cycles -> arvalid_o stays 1 with ar_data_o constant, then one handshake and outstd[1]=1.
REQ-038 Master 0 issues 4 bursts with no R data (MAX_OUTSTD=4) -> req_ready_o[0] stays 0 while master 1 is still granted; one R beat with rlast=1, rid=0 -> master 0 is eligible again.
REQ-039 AR handshake for master 1 in the same cycle as an R beat with rlast=1, rid=1, while outstd[1]=2 -> outstd[1] remains 2.
REQ-040 R beat with rid=3 and rready_i=0 -> rready_o=1, bad_rid_o pulses once, all counters unchanged.
REQ-041 rst_n=0 during ISSUE with arready_i=1 -> next cycle arvalid_o=0, all outstd=0, and the first grant after reset goes to master 0.
